// File: rtl/simon_core_param_if.sv
// Host-side bus of the SIMON core: key load, block in/out and the handshakes around them.
interface simon_core_param_if #(
  parameter int unsigned N = 64,
  parameter int unsigned M = 4
);
  logic                newKey;
  logic [M-1:0][N-1:0] KEY;
  logic                newData;
  logic                enc_dec;
  logic [1:0][N-1:0]   blockIN;
  logic                readData;
  logic                loadKey;
  logic                loadData;
  logic                doneKey;
  logic                doneData;
  logic [1:0][N-1:0]   outData;

  modport master (
    output newKey, KEY, newData, enc_dec, blockIN, readData,
    input  loadKey, loadData, doneKey, doneData, outData
  );

  modport slave (
    input  newKey, KEY, newData, enc_dec, blockIN, readData,
    output loadKey, loadData, doneKey, doneData, outData
  );
endinterface

// File: rtl/simon_core_param.sv
// Iterative SIMON 2N/MN core, one round per clock. The key is expanded once into a
// T-entry store, so decryption simply replays the stored round keys in reverse order.
module simon_core_param #(
  parameter int unsigned N  = 64,
  parameter int unsigned M  = 4,
  parameter int unsigned T  = 72,
  parameter int unsigned J  = 4,
  parameter int unsigned Cb = 7
) (
  input  logic              clk,
  input  logic              nR,
  simon_core_param_if.slave bus
);
  localparam int unsigned AW = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned ZL = 62;

  typedef enum logic [2:0] {NOKEY, EXPAND, READY, RUN, DONE} state_t;

  // z sequences written first-bit-leftmost, so z_J[i] lives at bit ZL-1-i
  function automatic logic [ZL-1:0] z_const(input int unsigned j);
    case (j)
      0:       z_const = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       z_const = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       z_const = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       z_const = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: z_const = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  localparam logic [ZL-1:0] ZJ = z_const(J);

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  state_t            state, state_n;
  logic [Cb-1:0]     cnt, cnt_n;
  logic [5:0]        zi, zi_n;
  logic [N-1:0]      x, x_n, y, y_n;
  logic              dec, dec_n;
  logic [1:0][N-1:0] out_q, out_n;
  logic              load_key_q, load_key_n, load_data_q, load_data_n;
  logic              done_key_q, done_key_n, done_data_q, done_data_n;
  logic              ks_init, ks_we;
  logic              key_go, data_go;
  logic [N-1:0]      ks [T];
  logic [N-1:0]      k_tmp, k_new, rk, x_rnd;
  logic [AW-1:0]     kidx;

  assign key_go  = bus.newKey & load_key_q;
  assign data_go = bus.newData & load_data_q;

  // Next key word from the words already in the store
  always_comb begin
    k_tmp = rotr(ks[AW'(cnt - Cb'(1))], 3);
    if (M == 4) k_tmp = k_tmp ^ ks[AW'(cnt - Cb'(3))];
    k_tmp = k_tmp ^ rotr(k_tmp, 1);
    k_new = ~ks[AW'(cnt - Cb'(M))] ^ k_tmp ^ N'(ZJ[6'(ZL - 1) - zi]) ^ N'(3);
  end

  // One Feistel round with the key picked by direction
  always_comb begin
    kidx  = dec ? AW'(Cb'(T - 1) - cnt) : AW'(cnt);
    rk    = ks[kidx];
    x_rnd = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ rk;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    zi_n        = zi;
    x_n         = x;
    y_n         = y;
    dec_n       = dec;
    out_n       = out_q;
    done_key_n  = 1'b0;
    done_data_n = done_data_q;
    ks_init     = 1'b0;
    ks_we       = 1'b0;
    unique case (state)
      NOKEY: begin
        if (key_go) begin
          state_n = EXPAND;
          ks_init = 1'b1;
          cnt_n   = Cb'(M);
          zi_n    = '0;
        end
      end
      EXPAND: begin
        ks_we = 1'b1;
        cnt_n = cnt + Cb'(1);
        zi_n  = (zi == 6'(ZL - 1)) ? '0 : zi + 6'd1;
        if (cnt == Cb'(T - 1)) begin
          state_n    = READY;
          done_key_n = 1'b1;
        end
      end
      READY, DONE: begin
        // newKey outranks newData; a block offered alongside a key is dropped
        if (key_go) begin
          state_n     = EXPAND;
          ks_init     = 1'b1;
          cnt_n       = Cb'(M);
          zi_n        = '0;
          done_data_n = 1'b0;
        end else if (data_go) begin
          state_n     = RUN;
          cnt_n       = '0;
          dec_n       = ~bus.enc_dec;
          x_n         = bus.enc_dec ? bus.blockIN[1] : bus.blockIN[0];
          y_n         = bus.enc_dec ? bus.blockIN[0] : bus.blockIN[1];
          done_data_n = 1'b0;
        end else if ((state == DONE) && bus.readData) begin
          state_n     = READY;
          done_data_n = 1'b0;
        end
      end
      RUN: begin
        x_n   = x_rnd;
        y_n   = x;
        cnt_n = cnt + Cb'(1);
        if (cnt == Cb'(T - 1)) begin
          state_n     = DONE;
          done_data_n = 1'b1;
          out_n       = dec ? {x, x_rnd} : {x_rnd, x};
        end
      end
      default: state_n = NOKEY;
    endcase
    load_key_n  = (state_n == NOKEY) || (state_n == READY) || (state_n == DONE);
    load_data_n = (state_n == READY) || (state_n == DONE);
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state       <= NOKEY;
      cnt         <= '0;
      zi          <= '0;
      x           <= '0;
      y           <= '0;
      dec         <= 1'b0;
      out_q       <= '0;
      load_key_q  <= 1'b0;
      load_data_q <= 1'b0;
      done_key_q  <= 1'b0;
      done_data_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      zi          <= zi_n;
      x           <= x_n;
      y           <= y_n;
      dec         <= dec_n;
      out_q       <= out_n;
      load_key_q  <= load_key_n;
      load_data_q <= load_data_n;
      done_key_q  <= done_key_n;
      done_data_q <= done_data_n;
    end
  end

  // Round-key store; its contents only matter once the FSM has left NOKEY
  always_ff @(posedge clk) begin
    if (ks_init) begin
      for (int i = 0; i < int'(M); i++) ks[AW'(i)] <= bus.KEY[MW'(i)];
    end else if (ks_we) begin
      ks[AW'(cnt)] <= k_new;
    end
  end

  assign bus.loadKey  = load_key_q;
  assign bus.loadData = load_data_q;
  assign bus.doneKey  = done_key_q;
  assign bus.doneData = done_data_q;
  assign bus.outData  = out_q;
endmodule

// File: tb/tb_simon_core_param.sv
// Bench for simon_core_param: SIMON32/64 and SIMON128/256 instances, queued expectations
// checked by a negedge monitor.
module tb_simon_core_param;
  localparam int unsigned NA = 16, MA = 4, TA = 32, JA = 0, CA = 6;
  localparam int unsigned NB = 64, MB = 4, TB = 72, JB = 4, CB = 7;
  localparam logic [1:0] LK = 2'd3, LD = 2'd2, DK = 2'd1, DD = 2'd0;

  logic clk = 1'b0;
  logic nr_a, nr_b;
  always #5 clk = ~clk;

  simon_core_param_if #(.N(NA), .M(MA)) ba ();
  simon_core_param_if #(.N(NB), .M(MB)) bb ();

  simon_core_param #(.N(NA), .M(MA), .T(TA), .J(JA), .Cb(CA)) dut_a (
    .clk(clk), .nR(nr_a), .bus(ba)
  );
  simon_core_param #(.N(NB), .M(MB), .T(TB), .J(JB), .Cb(CB)) dut_b (
    .clk(clk), .nR(nr_b), .bus(bb)
  );

  typedef struct {
    string        name;
    logic [127:0] act;
    logic [127:0] exp;
    bit           neq;
  } chk_t;

  chk_t dq[$];
  chk_t sqa[$];
  chk_t sqb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   fin_req = 1'b0;
  logic pa = 1'b0, pb = 1'b0;

  function automatic void judge(input chk_t c);
    bit bad;
    bad = c.neq ? (c.act === c.exp) : (c.act !== c.exp);
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got %0h, required %s%0h", c.name, c.act,
               c.neq ? "anything except " : "", c.exp);
    end
  endfunction

  // Monitor: drains direct checks and compares each doneData rise against the queue head
  always @(negedge clk) begin
    chk_t c;
    while (dq.size() > 0) judge(dq.pop_front());
    if (ba.doneData === 1'b1 && pa !== 1'b1) begin
      if (sqa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_spurious_done: got %0h, required no result", ba.outData);
      end else begin
        c = sqa.pop_front(); c.act = 128'(ba.outData); judge(c);
      end
    end
    if (bb.doneData === 1'b1 && pb !== 1'b1) begin
      if (sqb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_spurious_done: got %0h, required no result", bb.outData);
      end else begin
        c = sqb.pop_front(); c.act = 128'(bb.outData); judge(c);
      end
    end
    pa = ba.doneData;
    pb = bb.doneData;
    if (fin_req) begin
      c.name = "scoreboard_drained"; c.act = 128'(sqa.size() + sqb.size());
      c.exp = 128'd0; c.neq = 1'b0;
      judge(c);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of run, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp; c.neq = 1'b0;
    dq.push_back(c);
  endfunction

  function automatic void expect_out(input bit b, input string name, input logic [127:0] exp,
                                     input bit neq);
    chk_t c;
    c.name = name; c.act = '0; c.exp = exp; c.neq = neq;
    if (b) sqb.push_back(c); else sqa.push_back(c);
  endfunction

  // {loadKey, loadData, doneKey, doneData}
  function automatic logic [3:0] flags(input bit b);
    return b ? {bb.loadKey, bb.loadData, bb.doneKey, bb.doneData}
             : {ba.loadKey, ba.loadData, ba.doneKey, ba.doneData};
  endfunction

  function automatic logic [127:0] outd(input bit b);
    return b ? 128'(bb.outData) : 128'(ba.outData);
  endfunction

  task automatic set_in(input bit b, input bit nk, input bit nd, input bit rd);
    if (b) begin bb.newKey = nk; bb.newData = nd; bb.readData = rd; end
    else   begin ba.newKey = nk; ba.newData = nd; ba.readData = rd; end
  endtask

  task automatic set_key(input bit b, input logic [63:0] k3, k2, k1, k0);
    if (b) bb.KEY = {k3, k2, k1, k0};
    else   ba.KEY = {k3[15:0], k2[15:0], k1[15:0], k0[15:0]};
  endtask

  task automatic set_blk(input bit b, input bit enc, input logic [63:0] x, y);
    if (b) begin bb.enc_dec = enc; bb.blockIN = {x, y}; end
    else   begin ba.enc_dec = enc; ba.blockIN = {x[15:0], y[15:0]}; end
  endtask

  task automatic wait_flag(input bit b, input logic [1:0] f, input int budget, input string name,
                           output int cyc);
    logic [3:0] fl;
    cyc = 0;
    fl = flags(b);
    while (fl[f] !== 1'b1 && cyc < budget) begin tick(); cyc++; fl = flags(b); end
    if (fl[f] !== 1'b1) chk({name, "_timeout"}, 128'(cyc), 128'(budget + 1));
  endtask

  task automatic load_key(input bit b, input logic [63:0] k3, k2, k1, k0, input string name);
    int cyc;
    int lat;
    lat = b ? int'(TB - MB) : int'(TA - MA);
    wait_flag(b, LK, 20, name, cyc);
    set_key(b, k3, k2, k1, k0);
    set_in(b, 1'b1, 1'b0, 1'b0); tick(); set_in(b, 1'b0, 1'b0, 1'b0);
    wait_flag(b, DK, 200, name, cyc);
    chk({name, "_latency"}, 128'(cyc), 128'(lat));
    tick();
    chk({name, "_pulse"}, 128'(flags(b)), 128'(4'b1100));
  endtask

  task automatic start_data(input bit b, input bit enc, input logic [63:0] x, y, input string name);
    int cyc;
    wait_flag(b, LD, 20, name, cyc);
    set_blk(b, enc, x, y);
    set_in(b, 1'b0, 1'b1, 1'b0); tick(); set_in(b, 1'b0, 1'b0, 1'b0);
  endtask

  // Runs one block; a stray newData with another block is offered mid-run and must be ignored
  task automatic run_block(input bit b, input bit enc, input logic [63:0] x, y,
                           input logic [127:0] exp, input bit neq, input string name,
                           output logic [127:0] res);
    int cyc;
    int lat;
    lat = b ? int'(TB) : int'(TA);
    expect_out(b, name, exp, neq);
    start_data(b, enc, x, y, name);
    tick(); tick();
    set_blk(b, 1'b1, 64'h1, 64'h2);
    set_in(b, 1'b0, 1'b1, 1'b0); tick(); set_in(b, 1'b0, 1'b0, 1'b0);
    chk({name, "_run_flags"}, 128'(flags(b)), 128'(4'b0000));
    wait_flag(b, DD, 200, name, cyc);
    chk({name, "_latency"}, 128'(cyc + 3), 128'(lat));
    res = outd(b);
  endtask

  task automatic read_out(input bit b, input string name);
    set_in(b, 1'b0, 1'b0, 1'b1); tick(); set_in(b, 1'b0, 1'b0, 1'b0);
    chk({name, "_read"}, 128'(flags(b)), 128'(4'b1100));
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] ct2;
    int cyc;
    nr_a = 1'b0; nr_b = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0); set_in(1'b1, 1'b0, 1'b0, 1'b0);
    set_key(1'b0, '0, '0, '0, '0);  set_key(1'b1, '0, '0, '0, '0);
    set_blk(1'b0, 1'b1, '0, '0);    set_blk(1'b1, 1'b1, '0, '0);
    tick(); tick();
    chk("reset_flags_a", 128'(flags(1'b0)), 128'(4'b0000));
    chk("reset_out_a", outd(1'b0), 128'd0);
    nr_a = 1'b1; nr_b = 1'b1;
    tick();
    chk("post_reset_a", 128'(flags(1'b0)), 128'(4'b1000));

    set_blk(1'b0, 1'b1, 64'h6565, 64'h6877);
    set_in(1'b0, 1'b0, 1'b1, 1'b0); tick(); tick(); set_in(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("nokey_newdata_flags", 128'(flags(1'b0)), 128'(4'b1000));
    chk("nokey_newdata_out", outd(1'b0), 128'd0);

    load_key(1'b0, 64'h1918, 64'h1110, 64'h0908, 64'h0100, "a_key");
    run_block(1'b0, 1'b1, 64'h6565, 64'h6877, 128'hc69be9bb, 1'b0, "a_enc", res);
    repeat (3) tick();
    chk("a_done_hold_flags", 128'(flags(1'b0)), 128'(4'b1101));
    chk("a_done_hold_out", outd(1'b0), 128'hc69be9bb);
    read_out(1'b0, "a_enc");
    run_block(1'b0, 1'b0, 64'hc69b, 64'he9bb, 128'h65656877, 1'b0, "a_dec", res);
    run_block(1'b0, 1'b1, 64'h6565, 64'h6877, 128'hc69be9bb, 1'b0, "a_chain", res);
    read_out(1'b0, "a_chain");

    set_key(1'b0, 64'h1918, 64'h1110, 64'h0908, 64'h0100);
    set_blk(1'b0, 1'b1, 64'h1111, 64'h2222);
    set_in(1'b0, 1'b1, 1'b1, 1'b0); tick(); set_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_keydata_flags", 128'(flags(1'b0)), 128'(4'b0000));
    wait_flag(1'b0, DK, 100, "a_keydata", cyc);
    chk("a_keydata_latency", 128'(cyc), 128'(TA - MA));
    tick();
    chk("a_keydata_ready", 128'(flags(1'b0)), 128'(4'b1100));
    chk("a_ready_keeps_out", outd(1'b0), 128'hc69be9bb);

    load_key(1'b0, 64'h1918, 64'h1110, 64'h0908, 64'h0101, "a_key2");
    run_block(1'b0, 1'b1, 64'h6565, 64'h6877, 128'hc69be9bb, 1'b1, "a_enc_key2", ct2);
    read_out(1'b0, "a_enc_key2");
    run_block(1'b0, 1'b0, 64'(ct2[31:16]), 64'(ct2[15:0]), 128'h65656877, 1'b0, "a_dec_key2", res);
    read_out(1'b0, "a_dec_key2");
    load_key(1'b0, 64'h1918, 64'h1110, 64'h0908, 64'h0100, "a_key3");
    run_block(1'b0, 1'b0, 64'hc69b, 64'he9bb, 128'h65656877, 1'b0, "a_dec_key1", res);
    read_out(1'b0, "a_dec_key1");

    start_data(1'b0, 1'b1, 64'h6565, 64'h6877, "a_abort");
    repeat (10) tick();
    nr_a = 1'b0; #1;
    chk("abort_flags", 128'(flags(1'b0)), 128'(4'b0000));
    chk("abort_out", outd(1'b0), 128'd0);
    tick(); nr_a = 1'b1; tick();
    chk("abort_release", 128'(flags(1'b0)), 128'(4'b1000));
    set_in(1'b0, 1'b0, 1'b1, 1'b0); tick(); tick(); set_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_newdata_ignored", 128'(flags(1'b0)), 128'(4'b1000));
    load_key(1'b0, 64'h1918, 64'h1110, 64'h0908, 64'h0100, "a_key4");
    run_block(1'b0, 1'b1, 64'h6565, 64'h6877, 128'hc69be9bb, 1'b0, "a_enc_after_reset", res);
    read_out(1'b0, "a_enc_after_reset");

    load_key(1'b1, 64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
             64'h0f0e0d0c0b0a0908, 64'h0706050403020100, "b_key");
    run_block(1'b1, 1'b1, 64'h74206e69206d6f6f, 64'h6d69732061207369,
              128'h8d2b5579afc8a3a03bf72a87efe7b868, 1'b0, "b_enc", res);
    read_out(1'b1, "b_enc");
    run_block(1'b1, 1'b0, 64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868,
              128'h74206e69206d6f6f6d69732061207369, 1'b0, "b_dec", res);
    read_out(1'b1, "b_dec");

    repeat (3) tick();
    fin_req = 1'b1;
    repeat (5) tick();
  end
endmodule
